// File: rtl/hilo_muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_pkg
//   Shared definitions for the HI/LO multiply/divide unit: opcode encodings,
//   FSM state type and small opcode-decode helpers.
// -----------------------------------------------------------------------------
package hilo_muldiv_unit_pkg;

  localparam logic [2:0] MD_OP_NOP   = 3'b000;
  localparam logic [2:0] MD_OP_MULT  = 3'b001;
  localparam logic [2:0] MD_OP_MULTU = 3'b010;
  localparam logic [2:0] MD_OP_DIV   = 3'b011;
  localparam logic [2:0] MD_OP_DIVU  = 3'b100;
  localparam logic [2:0] MD_OP_MTHI  = 3'b101;
  localparam logic [2:0] MD_OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // True for the four opcodes that run the iterative datapath.
  function automatic logic md_is_iter(input logic [2:0] op);
    logic r;
    case (op)
      MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the two's-complement opcodes (operands converted to magnitudes).
  function automatic logic md_is_signed(input logic [2:0] op);
    logic r;
    case (op)
      MD_OP_MULT, MD_OP_DIV: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the divide opcodes.
  function automatic logic md_is_div(input logic [2:0] op);
    logic r;
    case (op)
      MD_OP_DIV, MD_OP_DIVU: r = 1'b1;
      MD_OP_NOP:             r = 1'b0;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_if
//   Request/result bundle between the EX stage and the multiply/divide unit.
//   master: issues start/op/rs_val/rt_val, observes busy/done/hi/lo.
//   slave : the multiply/divide unit itself.
// -----------------------------------------------------------------------------
interface hilo_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (output start, op, rs_val, rt_val, input busy, done, hi, lo);
  modport slave  (input start, op, rs_val, rt_val, output busy, done, hi, lo);
endinterface

// File: rtl/hilo_muldiv_unit_md_sign_fix.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit_md_sign_fix
//   Combinational sign correction of the raw unsigned-magnitude result.
//   Ports:
//     i_raw    raw result: mult = 64-bit product, div = {remainder, quotient}
//     i_is_div result comes from a divide
//     i_neg_q  product / quotient must be negated
//     i_neg_r  remainder must be negated (dividend was negative)
//     i_div0   divisor was zero
//     o_hi     corrected HI value
//     o_lo     corrected LO value
// -----------------------------------------------------------------------------
module hilo_muldiv_unit_md_sign_fix #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic [2*DATA_W-1:0] i_raw,
  input  logic                i_is_div,
  input  logic                i_neg_q,
  input  logic                i_neg_r,
  input  logic                i_div0,
  output logic [DATA_W-1:0]   o_hi,
  output logic [DATA_W-1:0]   o_lo
);

  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_quo;

  // Negate the relevant halves according to the latched sign flags.
  always_comb begin
    w_prod = i_neg_q ? -i_raw : i_raw;
    w_rem  = i_raw[2*DATA_W-1:DATA_W];
    w_quo  = i_raw[DATA_W-1:0];
    if (i_is_div) begin
      // Remainder takes the dividend's sign; on divide-by-zero the raw
      // remainder is |rs|, so this restores the original rs_val.
      o_hi = i_neg_r ? -w_rem : w_rem;
      if (i_div0) begin
        o_lo = DIV0_LO;
      end else if (i_neg_q) begin
        o_lo = -w_quo;
      end else begin
        o_lo = w_quo;
      end
    end else begin
      o_hi = w_prod[2*DATA_W-1:DATA_W];
      o_lo = w_prod[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// -----------------------------------------------------------------------------
// hilo_muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO registers.
//   MULT/MULTU/DIV/DIVU take 33 cycles (32 iterations + 1 sign-fix cycle);
//   MTHI/MTLO write in one cycle. busy stalls HI/LO consumers.
//   Ports:
//     i_clk    rising-edge clock
//     i_reset  synchronous active-high reset
//     md       slave side of hilo_muldiv_unit_if (start/op/rs_val/rt_val in,
//              busy/done/hi/lo out)
// -----------------------------------------------------------------------------
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  hilo_muldiv_unit_if.slave     md
);

  localparam int CNT_W = $clog2(DATA_W);

  md_state_t            r_state;
  md_state_t            w_state_nxt;
  logic [CNT_W-1:0]     r_count;
  // Shared shift register: mult = {acc, multiplier}, div = {rem, dividend/quotient}.
  logic [2*DATA_W-1:0]  r_sr;
  logic [DATA_W-1:0]    r_b;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_div0;
  logic                 r_busy;
  logic                 r_done;
  logic [DATA_W-1:0]    r_hi;
  logic [DATA_W-1:0]    r_lo;

  logic                 w_idle_req;
  logic                 w_accept;
  logic                 w_mthi;
  logic                 w_mtlo;
  logic                 w_last;
  logic                 w_signed;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [DATA_W-1:0]    w_mag_a;
  logic [DATA_W-1:0]    w_mag_b;
  logic [DATA_W:0]      w_sum;
  logic [DATA_W:0]      w_trial;
  logic                 w_ge;
  logic [DATA_W-1:0]    w_rem_sub;
  logic [2*DATA_W-1:0]  w_sr_nxt;
  logic [DATA_W-1:0]    w_fix_hi;
  logic [DATA_W-1:0]    w_fix_lo;

  // Request decode; anything arriving while not IDLE is dropped.
  always_comb begin
    w_idle_req = (r_state == IDLE) && md.start;
    w_accept   = w_idle_req && md_is_iter(md.op);
    w_mthi     = w_idle_req && (md.op == MD_OP_MTHI);
    w_mtlo     = w_idle_req && (md.op == MD_OP_MTLO);
    w_last     = (r_count == CNT_W'(DATA_W - 1));
  end

  // Operand conditioning: signed ops work on magnitudes plus sign flags.
  always_comb begin
    w_signed = md_is_signed(md.op);
    w_sign_a = w_signed & md.rs_val[DATA_W-1];
    w_sign_b = w_signed & md.rt_val[DATA_W-1];
    w_mag_a  = w_sign_a ? -md.rs_val : md.rs_val;
    w_mag_b  = w_sign_b ? -md.rt_val : md.rt_val;
  end

  // One shift-add (mult) or restoring-divide (div) step.
  always_comb begin
    w_sum     = {1'b0, r_sr[2*DATA_W-1:DATA_W]}
              + (r_sr[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
    // Partial remainder shifted left with the next dividend bit: 33 bits.
    w_trial   = r_sr[2*DATA_W-1:DATA_W-1];
    w_ge      = (w_trial >= {1'b0, r_b});
    // Difference is below the divisor, so the low DATA_W bits are exact.
    w_rem_sub = w_trial[DATA_W-1:0] - r_b;
    if (r_is_div) begin
      if (w_ge) begin
        w_sr_nxt = {w_rem_sub, r_sr[DATA_W-2:0], 1'b1};
      end else begin
        w_sr_nxt = {r_sr[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      w_sr_nxt = {w_sum, r_sr[DATA_W-1:1]};
    end
  end

  // FSM next-state: IDLE -> RUN (32 iterations) -> FIX -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = FIX;
        end else begin
          w_state_nxt = RUN;
        end
      end
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  hilo_muldiv_unit_md_sign_fix #(
    .DATA_W  (DATA_W),
    .DIV0_LO (DIV0_LO)
  ) u_sign_fix (
    .i_raw    (r_sr),
    .i_is_div (r_is_div),
    .i_neg_q  (r_neg_q),
    .i_neg_r  (r_neg_r),
    .i_div0   (r_div0),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  // State register, datapath registers and HI/LO update.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_count  <= {CNT_W{1'b0}};
      r_sr     <= {(2*DATA_W){1'b0}};
      r_b      <= {DATA_W{1'b0}};
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {DATA_W{1'b0}};
      r_lo     <= {DATA_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sr     <= {{DATA_W{1'b0}}, w_mag_a};
            r_b      <= w_mag_b;
            r_is_div <= md_is_div(md.op);
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_div0   <= (md.rt_val == {DATA_W{1'b0}});
            r_count  <= {CNT_W{1'b0}};
            r_busy   <= 1'b1;
          end else begin
            if (w_mthi) begin
              r_hi <= md.rs_val;
            end
            if (w_mtlo) begin
              r_lo <= md.rs_val;
            end
          end
        end
        RUN: begin
          r_sr    <= w_sr_nxt;
          r_count <= r_count + CNT_W'(1);
        end
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = r_busy;
  assign md.done = r_done;
  assign md.hi   = r_hi;
  assign md.lo   = r_lo;

endmodule
